// File: rtl/fetch_controller.sv
// fetch_controller: single-outstanding-request instruction fetch unit.
// Issues one word-aligned request at a time, presents the returned word to
// decode and holds it until consumed. Redirects that land while a request is
// outstanding and unanswered are parked in pend_target, and the stale
// response is dropped (DRAIN) before fetching from the new address.
module fetch_controller #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] Instruction,
  output logic [63:0] inst_pc,
  input  logic        dec_ready,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  r_state;
  logic [63:0] r_pc;
  logic [63:0] r_pend_target;
  logic        r_inst_valid;
  logic [31:0] r_instruction;
  logic [63:0] r_inst_pc;
  logic [31:0] r_fetch_count;

  logic [63:0] w_target;

  // Redirect target with the byte-offset bits forced to zero.
  assign w_target = {redirect_target[63:2], 2'b00};

  // Fetch sequencing, PC update, instruction latch and consume counter.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every branch
    // below reads the pre-edge values, regardless of statement order.
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_pend_target <= 64'd0;
      r_inst_valid  <= 1'b0;
      r_instruction <= 32'd0;
      r_inst_pc     <= 64'd0;
      r_fetch_count <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;

        S_FETCH: begin
          if (imem_ready) begin
            if (redirect) begin
              // Response arrives with a redirect: drop it, refetch at target.
              r_pc <= w_target;
            end else begin
              r_instruction <= imem_rdata;
              r_inst_pc     <= r_pc;
              r_inst_valid  <= 1'b1;
              r_pc          <= r_pc + 64'd4;
              r_state       <= S_HOLD;
            end
          end else if (redirect) begin
            // Address must stay stable until the memory answers, so park
            // the target and drain the outstanding request first.
            r_pend_target <= w_target;
            r_state       <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (imem_ready) begin
            r_pc    <= redirect ? w_target : r_pend_target;
            r_state <= S_FETCH;
          end else if (redirect) begin
            r_pend_target <= w_target;
          end
        end

        S_HOLD: begin
          if (dec_ready || redirect) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_FETCH;
            if (dec_ready) r_fetch_count <= r_fetch_count + 32'd1;
            if (redirect)  r_pc          <= w_target;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign imem_addr   = r_pc;
  assign inst_valid  = r_inst_valid;
  assign Instruction = r_instruction;
  assign inst_pc     = r_inst_pc;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: two instances (RESET_PC = 0 and a wrapping RESET_PC)
// share stimulus; a behavioural model is compared every cycle, and directed
// sequences pin literal values.
module tb_fetch_controller;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_target = 64'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        dec_ready = 1'b0;

  logic        o_req   [2];
  logic [63:0] o_addr  [2];
  logic        o_valid [2];
  logic [31:0] o_inst  [2];
  logic [63:0] o_ipc   [2];
  logic [31:0] o_cnt   [2];

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  bit load_cnt = 1'b0;

  always #5 clk = ~clk;

  fetch_controller #(.RESET_PC(64'd0)) u0 (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(o_req[0]), .imem_addr(o_addr[0]), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst_valid(o_valid[0]), .Instruction(o_inst[0]),
    .inst_pc(o_ipc[0]), .dec_ready(dec_ready), .fetch_count(o_cnt[0])
  );

  fetch_controller #(.RESET_PC(WRAP_PC)) u1 (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(o_req[1]), .imem_addr(o_addr[1]), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst_valid(o_valid[1]), .Instruction(o_inst[1]),
    .inst_pc(o_ipc[1]), .dec_ready(dec_ready), .fetch_count(o_cnt[1])
  );

  // Behavioural model: "boot" is the one dead cycle after reset, "have" means
  // a word is waiting for decode, "discard" means the outstanding response is
  // stale and the next fetch goes to "pend".
  typedef struct {
    bit          boot;
    bit          have;
    bit          discard;
    logic [63:0] pc;
    logic [63:0] pend;
    logic [63:0] ipc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } model_t;

  model_t m [2];

  function automatic model_t fresh(input logic [63:0] rpc);
    model_t r;
    r.boot = 1'b1; r.have = 1'b0; r.discard = 1'b0;
    r.pc = rpc; r.pend = 64'd0; r.ipc = 64'd0; r.inst = 32'd0; r.cnt = 32'd0;
    return r;
  endfunction

  function automatic model_t advance(input model_t s, input logic [63:0] rpc);
    model_t      r;
    logic [63:0] tgt;
    r   = s;
    tgt = redirect_target & ~64'd3;
    if (reset) begin
      r = fresh(rpc);
    end else if (s.boot) begin
      r.boot = 1'b0;
    end else if (s.have) begin
      if (dec_ready) r.cnt = s.cnt + 32'd1;
      if (dec_ready || redirect) r.have = 1'b0;
      if (redirect) r.pc = tgt;
    end else if (imem_ready) begin
      if (s.discard) begin
        r.pc = redirect ? tgt : s.pend;
        r.discard = 1'b0;
      end else if (redirect) begin
        r.pc = tgt;
      end else begin
        r.inst = imem_rdata;
        r.ipc  = s.pc;
        r.have = 1'b1;
        r.pc   = s.pc + 64'd4;
      end
    end else if (redirect) begin
      r.pend    = tgt;
      r.discard = 1'b1;
    end
    return r;
  endfunction

  // Model update on every rising edge from the inputs the DUT also samples.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load_cnt) m[i].cnt = 32'hFFFF_FFFF;
      m[i] = advance(m[i], (i == 0) ? 64'd0 : WRAP_PC);
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cycle_u%0d", i),
              {o_req[i], o_addr[i], o_valid[i], o_inst[i], o_ipc[i], o_cnt[i]},
              {!(m[i].boot || m[i].have), m[i].pc, m[i].have, m[i].inst, m[i].ipc, m[i].cnt});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit rd, input logic [63:0] t, input bit ry, input bit dr);
    redirect = rd; redirect_target = t; imem_ready = ry; dec_ready = dr;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   o_req[0],   0);
    check({tag, "_valid"}, o_valid[0], 0);
    check({tag, "_inst"},  o_inst[0],  0);
    check({tag, "_ipc"},   o_ipc[0],   0);
    check({tag, "_cnt"},   o_cnt[0],   0);
    check({tag, "_addr"},  o_addr[0],  0);
  endtask

  logic [31:0] held_inst;
  logic [63:0] held_ipc;

  initial begin
    // Reset and the first request two cycles after release.
    reset = 1'b1;
    tick();
    tick();
    cmp_en = 1'b1;
    reset = 1'b0;
    check_reset_values("reset");
    tick();
    check("first_req", o_req[0], 1);
    check("first_addr", o_addr[0], 0);
    check("first_addr_wrap", o_addr[1], WRAP_PC);

    // Streaming with both handshakes held high: one instruction per 2 cycles.
    set_in(1'b0, 64'd0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      imem_rdata = o_addr[0][31:0];
      tick();
      check("stream_valid", o_valid[0], 1);
      check("stream_ipc", o_ipc[0], 4 * k);
      check("stream_inst", o_inst[0], 4 * k);
      if (k == 0) begin
        check("wrap_ipc", o_ipc[1], WRAP_PC);
        check("wrap_next_addr", o_addr[1], 0);
      end
      imem_rdata = o_addr[0][31:0];
      tick();
      check("stream_cnt", o_cnt[0], k + 1);
      check("stream_gap_valid", o_valid[0], 0);
    end

    // Backpressure: held instruction stays put, exactly one consume.
    set_in(1'b0, 64'd0, 1'b1, 1'b0);
    imem_rdata = 32'h0000_000C;
    tick();
    held_inst = o_inst[0];
    held_ipc  = o_ipc[0];
    check("bp_ipc", held_ipc, 64'hC);
    imem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_inst_stable", o_inst[0], held_inst);
      check("bp_ipc_stable", o_ipc[0], held_ipc);
      check("bp_req_low", o_req[0], 0);
      check("bp_valid", o_valid[0], 1);
    end
    dec_ready = 1'b1;
    tick();
    check("bp_consume", o_cnt[0], 4);
    dec_ready = 1'b0;
    tick();
    check("bp_single_consume", o_cnt[0], 4);
    check("bp_next_addr", o_addr[0], 64'h10);

    // Redirects while the request waits; the last one wins.
    set_in(1'b1, 64'h103, 1'b0, 1'b0);
    tick();
    check("drain_addr_hold", o_addr[0], 64'h10);
    check("drain_req", o_req[0], 1);
    redirect = 1'b0;
    tick();
    tick();
    check("drain_addr_hold2", o_addr[0], 64'h10);
    set_in(1'b1, 64'h207, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 64'd0, 1'b1, 1'b0);
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("drain_discard", o_valid[0], 0);
    check("drain_new_addr", o_addr[0], 64'h204);
    imem_rdata = 32'h0000_1234;
    tick();
    check("after_drain_ipc", o_ipc[0], 64'h204);
    check("after_drain_inst", o_inst[0], 32'h1234);

    // Redirect collisions in HOLD and FETCH.
    set_in(1'b1, 64'h40, 1'b0, 1'b0);
    tick();
    check("hold_squash_valid", o_valid[0], 0);
    check("hold_squash_cnt", o_cnt[0], 4);
    check("hold_squash_addr", o_addr[0], 64'h40);
    set_in(1'b1, 64'h81, 1'b1, 1'b0);
    tick();
    check("fetch_redir_valid", o_valid[0], 0);
    check("fetch_redir_addr", o_addr[0], 64'h80);
    set_in(1'b0, 64'd0, 1'b1, 1'b0);
    tick();
    check("fetch_redir_ipc", o_ipc[0], 64'h80);
    set_in(1'b1, 64'hC0, 1'b0, 1'b1);
    tick();
    check("hold_redir_consume", o_cnt[0], 5);
    check("hold_redir_addr", o_addr[0], 64'hC0);

    // fetch_count wrap-around.
    set_in(1'b0, 64'd0, 1'b1, 1'b0);
    tick();
    cmp_en = 1'b0;
    force u0.r_fetch_count = 32'hFFFF_FFFF;
    force u1.r_fetch_count = 32'hFFFF_FFFF;
    #1;
    release u0.r_fetch_count;
    release u1.r_fetch_count;
    load_cnt = 1'b1;
    set_in(1'b0, 64'd0, 1'b0, 1'b1);
    tick();
    load_cnt = 1'b0;
    cmp_en = 1'b1;
    check("cnt_wrap", o_cnt[0], 0);

    // Reset with an instruction held.
    set_in(1'b0, 64'd0, 1'b1, 1'b0);
    tick();
    check("pre_reset_hold", o_valid[0], 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("rst_hold");
    tick();
    check("rst_hold_req", o_req[0], 1);

    // Reset with a stale request being drained.
    set_in(1'b1, 64'h55, 1'b0, 1'b0);
    tick();
    redirect = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("rst_drain");
    tick();
    check("rst_drain_req", o_req[0], 1);
    check("rst_drain_addr_wrap", o_addr[1], WRAP_PC);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 199) == 0);
      redirect        = ($urandom_range(0, 4) == 0);
      redirect_target = {$urandom, $urandom};
      imem_ready      = ($urandom_range(0, 9) < 6);
      dec_ready       = ($urandom_range(0, 9) < 6);
      imem_rdata      = $urandom;
      tick();
    end
    reset = 1'b0;
    tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
